ql_sync_fifo: RTL and testbench

QL_SYNC_FIFO -- requirements
Module: ql_sync_fifo

---
 rtl/ql_sync_fifo.sv | 118 +++++++++++
 tb/tb_ql_sync_fifo.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ql_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy level, threshold flags and sticky over/underflow.
// Latency: write-to-read 1 cycle, no bypass; a rejected write or read is dropped and only sets the sticky flag.
module ql_sync_fifo #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 9,
    parameter int UPAE   = 4,
    parameter int UPAF   = 4
) (
    input  logic              CLK,
    input  logic              CLR_N,
    input  logic              FFLUSH,
    input  logic              WEN,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic              REN,
    output logic [WIDTH-1:0]  RDATA,
    output logic              RVALID,
    output logic [ADDR_W:0]   LEVEL,
    output logic              EMPTY,
    output logic              FULL,
    output logic              AEMPTY,
    output logic              AFULL,
    output logic              OVF,
    output logic              UDF
);

    localparam int             DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AE_TH    = (ADDR_W+1)'(UPAE);
    localparam logic [ADDR_W:0] AF_TH    = DEPTH_L - (ADDR_W+1)'(UPAF);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              empty, full;
    logic              wr_acc, rd_acc;

    // Flags decode only the registered level so they are glitch-free w.r.t. the request inputs.
    assign empty  = (level_q == '0);
    assign full   = (level_q == DEPTH_L);
    assign wr_acc = WEN & ~full  & ~FFLUSH & CLR_N;
    assign rd_acc = REN & ~empty & ~FFLUSH;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (FFLUSH) begin
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (wr_acc) begin
                wptr_d = wptr_q + PTR_ONE;
            end
            if (rd_acc) begin
                rptr_d   = rptr_q + PTR_ONE;
                rdata_d  = mem_q[rptr_q[ADDR_W-1:0]];
                rvalid_d = 1'b1;
            end
            if (WEN && full) begin
                ovf_d = 1'b1;
            end
            if (REN && empty) begin
                udf_d = 1'b1;
            end
        end
        // The wrap bit makes this difference span 0..DEPTH unambiguously.
        level_d = wptr_d - rptr_d;
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately not reset; EMPTY hides stale contents.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= WDATA;
        end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
    assign LEVEL  = level_q;
    assign EMPTY  = empty;
    assign FULL   = full;
    assign AEMPTY = (level_q <= AE_TH);
    assign AFULL  = (level_q >= AF_TH);
    assign OVF    = ovf_q;
    assign UDF    = udf_q;

endmodule

// File: tb/tb_ql_sync_fifo.sv
// Scoreboard bench for ql_sync_fifo at WIDTH=8, DEPTH=4, UPAE=1, UPAF=1.
module tb_ql_sync_fifo;

    logic       CLK = 1'b0;
    logic       CLR_N, FFLUSH, WEN, REN;
    logic [7:0] WDATA, RDATA;
    logic       RVALID, EMPTY, FULL, AEMPTY, AFULL, OVF, UDF;
    logic [2:0] LEVEL;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] sb[$];
    int         m_level  = 0;
    logic       m_ovf    = 1'b0;
    logic       m_udf    = 1'b0;
    logic       m_rv     = 1'b0;
    logic [7:0] m_last   = 8'h00;
    logic [7:0] exp_d;

    ql_sync_fifo #(.WIDTH(8), .ADDR_W(2), .UPAE(1), .UPAF(1)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .FFLUSH(FFLUSH), .WEN(WEN), .WDATA(WDATA),
        .REN(REN), .RDATA(RDATA), .RVALID(RVALID), .LEVEL(LEVEL), .EMPTY(EMPTY),
        .FULL(FULL), .AEMPTY(AEMPTY), .AFULL(AFULL), .OVF(OVF), .UDF(UDF)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of requests, update the reference model, then settle 1ns past the edge.
    task automatic tick(input logic wen, input logic [7:0] wd, input logic ren, input logic fl);
        bit wacc, racc;
        WEN = wen; WDATA = wd; REN = ren; FFLUSH = fl;
        wacc = wen && !fl && (m_level != 4);
        racc = ren && !fl && (m_level != 0);
        m_rv = racc;
        if (fl) begin
            sb.delete(); m_level = 0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            if (wen && m_level == 4) m_ovf = 1'b1;
            if (ren && m_level == 0) m_udf = 1'b1;
            if (wacc) sb.push_back(wd);
            m_level = m_level + int'(wacc) - int'(racc);
        end
        @(posedge CLK); #1;
        WEN = 1'b0; REN = 1'b0; FFLUSH = 1'b0;
    endtask

    task automatic test_reset;
        CLR_N = 1'b0; WEN = 1'b0; REN = 1'b0; FFLUSH = 1'b0; WDATA = 8'h00;
        #2;
        n_checks++; if ({LEVEL, EMPTY, AEMPTY, FULL, AFULL} !== 7'b000_1100) $display("FAIL reset_flags got %b want 0001100", {LEVEL, EMPTY, AEMPTY, FULL, AFULL}); else n_pass++;
        n_checks++; if ({RVALID, OVF, UDF, RDATA} !== 11'd0) $display("FAIL reset_outs got %h want 0", {RVALID, OVF, UDF, RDATA}); else n_pass++;
        @(posedge CLK); #2;
        CLR_N = 1'b1;
    endtask

    task automatic test_fill_drain;
        logic [7:0] vals [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, vals[i], 1'b0, 1'b0);
            n_checks++; if (LEVEL !== 3'(i+1)) $display("FAIL fill_level got %0d want %0d", LEVEL, i+1); else n_pass++;
            n_checks++; if ({AEMPTY, AFULL, FULL} !== {i+1 <= 1, i+1 >= 3, i+1 == 4}) $display("FAIL fill_flags lvl %0d got %b want %b", i+1, {AEMPTY, AFULL, FULL}, {i+1 <= 1, i+1 >= 3, i+1 == 4}); else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            n_checks++; if (RVALID !== 1'b1) $display("FAIL drain_rvalid got %b want 1", RVALID); else n_pass++;
            if (RVALID === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front(); m_last = exp_d;
                n_checks++; if (RDATA !== exp_d) $display("FAIL drain_data got %h want %h", RDATA, exp_d); else n_pass++;
            end
        end
        n_checks++; if ({EMPTY, LEVEL} !== 4'b1000) $display("FAIL drain_empty got %b want 1000", {EMPTY, LEVEL}); else n_pass++;
    endtask

    task automatic test_ovf_udf;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b0);
        n_checks++; if ({OVF, LEVEL, FULL} !== {m_ovf, 3'(m_level), 1'b1}) $display("FAIL ovf_set got %b want %b", {OVF, LEVEL, FULL}, {m_ovf, 3'(m_level), 1'b1}); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (RVALID === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front(); m_last = exp_d;
                n_checks++; if (RDATA !== exp_d) $display("FAIL ovf_data got %h want %h", RDATA, exp_d); else n_pass++;
            end else begin
                n_checks++; $display("FAIL ovf_rvalid got %b want 1", RVALID);
            end
        end
        n_checks++; if (OVF !== 1'b1) $display("FAIL ovf_sticky got %b want 1", OVF); else n_pass++;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if ({UDF, RVALID} !== {m_udf, m_rv}) $display("FAIL udf_set got %b want %b", {UDF, RVALID}, {m_udf, m_rv}); else n_pass++;
        n_checks++; if (RDATA !== m_last) $display("FAIL udf_hold got %h want %h", RDATA, m_last); else n_pass++;
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if ({OVF, UDF} !== 2'b00) $display("FAIL flags_clear got %b want 00", {OVF, UDF}); else n_pass++;
    endtask

    task automatic test_back_to_back;
        tick(1'b1, 8'h60, 1'b0, 1'b0);
        tick(1'b1, 8'h61, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 8'h70 + 8'(i), 1'b1, 1'b0);
            n_checks++; if (LEVEL !== 3'd2 || RVALID !== 1'b1) $display("FAIL b2b_level cyc %0d got %0d/%b want 2/1", i, LEVEL, RVALID); else n_pass++;
            if (RVALID === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front(); m_last = exp_d;
                n_checks++; if (RDATA !== exp_d) $display("FAIL b2b_data cyc %0d got %h want %h", i, RDATA, exp_d); else n_pass++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            if (RVALID === 1'b1 && sb.size() > 0) begin
                exp_d = sb.pop_front(); m_last = exp_d;
                n_checks++; if (RDATA !== exp_d) $display("FAIL b2b_tail got %h want %h", RDATA, exp_d); else n_pass++;
            end else begin
                n_checks++; $display("FAIL b2b_tail_rvalid got %b want 1", RVALID);
            end
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h31 + 8'(i), 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        if (RVALID === 1'b1 && sb.size() > 0) begin exp_d = sb.pop_front(); m_last = exp_d; end
        n_checks++; if ({LEVEL, OVF, RDATA} !== {3'd3, 1'b1, 8'h31}) $display("FAIL flush_pre got %h want %h", {LEVEL, OVF, RDATA}, {3'd3, 1'b1, 8'h31}); else n_pass++;
        tick(1'b1, 8'h77, 1'b1, 1'b1);
        n_checks++; if ({LEVEL, EMPTY, OVF, UDF, RVALID} !== 7'b000_1000) $display("FAIL flush_state got %b want 0001000", {LEVEL, EMPTY, OVF, UDF, RVALID}); else n_pass++;
        n_checks++; if (RDATA !== m_last) $display("FAIL flush_hold got %h want %h", RDATA, m_last); else n_pass++;
        tick(1'b1, 8'h42, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++; if ({RVALID, RDATA, EMPTY} !== {1'b1, exp_d, 1'b1}) $display("FAIL flush_after got %h want %h", {RVALID, RDATA, EMPTY}, {1'b1, exp_d, 1'b1}); else n_pass++;
    endtask

    task automatic test_async_reset;
        tick(1'b1, 8'h81, 1'b0, 1'b0);
        tick(1'b1, 8'h82, 1'b0, 1'b0);
        tick(1'b1, 8'h83, 1'b1, 1'b0);
        tick(1'b1, 8'h84, 1'b0, 1'b0);
        n_checks++; if ({LEVEL, RDATA} !== {3'd3, 8'h81}) $display("FAIL arst_pre got %h want %h", {LEVEL, RDATA}, {3'd3, 8'h81}); else n_pass++;
        #3 CLR_N = 1'b0;
        #1;
        n_checks++; if ({LEVEL, EMPTY, AEMPTY, FULL, AFULL, RVALID, OVF, UDF, RDATA} !== {3'd0, 4'b1100, 3'b000, 8'h00}) $display("FAIL arst_async got %h want %h", {LEVEL, EMPTY, AEMPTY, FULL, AFULL, RVALID, OVF, UDF, RDATA}, {3'd0, 4'b1100, 3'b000, 8'h00}); else n_pass++;
        sb.delete(); m_level = 0; m_ovf = 1'b0; m_udf = 1'b0;
        WEN = 1'b1; WDATA = 8'h99; REN = 1'b1;
        @(posedge CLK); #2;
        n_checks++; if ({LEVEL, RVALID} !== 4'b0000) $display("FAIL arst_ignore got %b want 0000", {LEVEL, RVALID}); else n_pass++;
        WEN = 1'b0; REN = 1'b0; CLR_N = 1'b1;
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        n_checks++; if (LEVEL !== 3'd1) $display("FAIL arst_wr got %0d want 1", LEVEL); else n_pass++;
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
        n_checks++; if ({RVALID, RDATA} !== {1'b1, exp_d}) $display("FAIL arst_rd got %h want %h", {RVALID, RDATA}, {1'b1, exp_d}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_ovf_udf();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
